lut_rd_arbiter: RTL and testbench

//  Shares one 256x24 MRELBP rd weight LUT (combinational ROM, 8b addr -> 24b weight) among N pixel pipelines.

---
 rtl/lut_rd_pkg.sv | 16 +
 rtl/lut_rd_arbiter_rr_arb.sv | 33 +++
 rtl/lut_rd_arbiter.sv | 97 +++++++++
 tb/tb_lut_rd_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_rd_pkg.sv
// Shared types and sizes for the MRELBP rd weight LUT and its read arbiter.
package lut_rd_pkg;

  localparam int LUT_AW    = 8;
  localparam int LUT_DW    = 24;
  localparam int LUT_DEPTH = 256;

  typedef logic [LUT_AW-1:0] lut_addr_t;
  typedef logic [LUT_DW-1:0] lut_data_t;

  // True when at least two bits of a request vector are set.
  function automatic logic multi_req(input logic [7:0] req);
    return (req & (req - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/lut_rd_arbiter_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module rr_arb #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  int   idx;
  logic found;

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[PW'(idx)]) begin
        found          = 1'b1;
        gnt[PW'(idx)]  = 1'b1;
        next_ptr       = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/lut_rd_arbiter.sv
// Round-robin shared read port for one 256x24 rd weight LUT, 2-cycle tagged return.
// Optional conflict statistics counter enabled by defining LUT_RD_STATS_EN.
module lut_rd_arbiter
  import lut_rd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*LUT_AW-1:0] i_addr,
  output logic [N_REQ-1:0]        o_gnt,
  output lut_addr_t               o_lut_addr,
  input  lut_data_t               i_lut_dout,
  output logic [N_REQ-1:0]        o_rvalid,
  output lut_data_t               o_rdata,
  output logic [CNT_W-1:0]        o_conflict_cnt
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    next_ptr;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  lut_addr_t        sel_addr;

  logic             s1_vld;
  logic [N_REQ-1:0] s1_tag;
  lut_addr_t        s1_addr;
  logic             s2_vld;
  logic [N_REQ-1:0] s2_tag;
  lut_data_t        s2_data;

  // Masking requests during reset keeps o_gnt low and the pointer frozen.
  assign arb_req = i_rst ? '0 : i_req;

  rr_arb #(.N(N_REQ), .PW(PW)) u_rr_arb (
    .req      (arb_req),
    .ptr      (ptr_q),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < N_REQ; k++)
      if (gnt[k]) sel_addr = i_addr[LUT_AW*k +: LUT_AW];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the pipeline stages shift in lockstep.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q   <= '0;
      s1_vld  <= 1'b0;
      s1_tag  <= '0;
      s1_addr <= '0;
      s2_vld  <= 1'b0;
      s2_tag  <= '0;
      s2_data <= '0;
    end else begin
      ptr_q  <= next_ptr;
      s1_vld <= |gnt;
      if (|gnt) begin
        s1_tag  <= gnt;
        s1_addr <= sel_addr;
      end
      s2_vld <= s1_vld;
      s2_tag <= s1_tag;
      if (s1_vld) s2_data <= i_lut_dout;
    end
  end

  assign o_gnt      = gnt;
  assign o_lut_addr = s1_addr;
  assign o_rdata    = s2_data;
  assign o_rvalid   = s2_vld ? s2_tag : '0;

`ifdef LUT_RD_STATS_EN
  logic [CNT_W-1:0] cnt_q;
  logic             conflict;

  assign conflict = multi_req(8'(i_req));

  always_ff @(posedge i_clk) begin
    if (i_rst)                       cnt_q <= '0;
    else if (conflict && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign o_conflict_cnt = cnt_q;
`else
  assign o_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_lut_rd_arbiter.sv
// Self-checking bench for lut_rd_arbiter against a queue-based return model.
module tb_lut_rd_arbiter;
  import lut_rd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  lane_addr [4];
  logic [31:0] addr_bus;
  logic [3:0]  gnt, gnt4, rvalid, rvalid4;
  lut_addr_t   lut_addr, lut_addr4;
  lut_data_t   lut_dout, lut_dout4, rdata, rdata4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  assign addr_bus  = {lane_addr[3], lane_addr[2], lane_addr[1], lane_addr[0]};
  assign lut_dout  = {lut_addr, lut_addr, lut_addr} ^ 24'h5A5A5A;
  assign lut_dout4 = {lut_addr4, lut_addr4, lut_addr4} ^ 24'h5A5A5A;

  lut_rd_arbiter #(.N_REQ(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr_bus), .o_gnt(gnt),
    .o_lut_addr(lut_addr), .i_lut_dout(lut_dout), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_conflict_cnt(cnt)
  );

  lut_rd_arbiter #(.N_REQ(4), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr_bus), .o_gnt(gnt4),
    .o_lut_addr(lut_addr4), .i_lut_dout(lut_dout4), .o_rvalid(rvalid4),
    .o_rdata(rdata4), .o_conflict_cnt(cnt4)
  );

  typedef struct {
    int         due;
    logic [3:0] tag;
    logic [23:0] data;
  } pend_t;

  pend_t       pend [$];
  int          m_ptr, m_cyc, m_gsel, m_cnt, m_cnt4;
  logic [23:0] m_rdata;
  logic [7:0]  m_lut_addr;
  logic [3:0]  exp_gnt, exp_rvalid;
  logic [23:0] exp_rdata;
  logic [7:0]  exp_lut_addr;
  logic [15:0] exp_cnt;
  logic [3:0]  exp_cnt4;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  function automatic logic [23:0] weight(input logic [7:0] a);
    return {a, a, a} ^ 24'h5A5A5A;
  endfunction

  // Work out what the DUT must show during the current cycle.
  task automatic observe();
    @(negedge clk);
    m_gsel  = rst ? -1 : rr_pick(req, m_ptr);
    exp_gnt = (m_gsel < 0) ? 4'b0 : 4'(1 << m_gsel);
    exp_rvalid = 4'b0;
    if (pend.size() > 0 && pend[0].due == m_cyc) begin
      exp_rvalid = pend[0].tag;
      m_rdata    = pend[0].data;
      void'(pend.pop_front());
    end
    exp_rdata    = m_rdata;
    exp_lut_addr = m_lut_addr;
`ifdef LUT_RD_STATS_EN
    exp_cnt  = 16'(m_cnt);
    exp_cnt4 = 4'(m_cnt4);
`else
    exp_cnt  = '0;
    exp_cnt4 = '0;
`endif
  endtask

  // Apply the effect of the coming clock edge to the model, then advance.
  task automatic commit();
    if (rst) begin
      pend.delete();
      m_ptr = 0; m_lut_addr = '0; m_rdata = '0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (m_gsel >= 0) begin
        pend.push_back('{due: m_cyc + 2, tag: 4'(1 << m_gsel),
                         data: weight(lane_addr[m_gsel])});
        m_lut_addr = lane_addr[m_gsel];
        m_ptr      = (m_gsel + 1) % 4;
      end
      if ($countones(req) >= 2) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      observe();
      n_checks += 3;
      if (gnt !== 4'b0) begin n_errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
      if (rvalid !== 4'b0) begin n_errors++; $display("FAIL reset_rvalid got %b exp 0000", rvalid); end
      if (rdata !== 24'h0) begin n_errors++; $display("FAIL reset_rdata got %h exp 000000", rdata); end
      commit();
    end
    rst = 1'b0;
    req = 4'h0;
    observe();
    n_checks += 2;
    if (lut_addr !== 8'h00) begin n_errors++; $display("FAIL reset_lut_addr got %h exp 00", lut_addr); end
    if (cnt !== 16'h0) begin n_errors++; $display("FAIL reset_cnt got %h exp 0000", cnt); end
    commit();
  endtask

  task automatic test_single_lane();
    req = 4'b0100;
    lane_addr[2] = 8'h3C;
    observe();
    n_checks++;
    if (gnt !== 4'b0100) begin n_errors++; $display("FAIL single_gnt got %b exp 0100", gnt); end
    commit();
    req = 4'b0000;
    lane_addr[2] = 8'hFF;
    observe();
    n_checks += 2;
    if (lut_addr !== 8'h3C) begin n_errors++; $display("FAIL single_lut_addr got %h exp 3c", lut_addr); end
    if (rvalid !== 4'b0) begin n_errors++; $display("FAIL single_early_rvalid got %b exp 0000", rvalid); end
    commit();
    observe();
    n_checks += 2;
    if (rvalid !== 4'b0100) begin n_errors++; $display("FAIL single_rvalid got %b exp 0100", rvalid); end
    if (rdata !== 24'h666666) begin n_errors++; $display("FAIL single_rdata got %h exp 666666", rdata); end
    commit();
    observe();
    n_checks += 2;
    if (rvalid !== 4'b0) begin n_errors++; $display("FAIL single_rvalid_pulse got %b exp 0000", rvalid); end
    if (rdata !== 24'h666666) begin n_errors++; $display("FAIL single_rdata_hold got %h exp 666666", rdata); end
    commit();
  endtask

  task automatic test_all_lanes();
    rst = 1'b1; req = 4'h0;
    observe(); commit();
    rst = 1'b0; req = 4'hF;
    for (int k = 0; k < 4; k++) lane_addr[k] = 8'($urandom);
    for (int i = 0; i < 14; i++) begin
      observe();
      n_checks += 5;
      if (gnt !== 4'(1 << (i % 4))) begin n_errors++; $display("FAIL all_gnt_order got %b exp %b", gnt, 4'(1 << (i % 4))); end
      if (gnt !== exp_gnt) begin n_errors++; $display("FAIL all_gnt got %b exp %b", gnt, exp_gnt); end
      if (rvalid !== exp_rvalid) begin n_errors++; $display("FAIL all_rvalid got %b exp %b", rvalid, exp_rvalid); end
      if (rdata !== exp_rdata) begin n_errors++; $display("FAIL all_rdata got %h exp %h", rdata, exp_rdata); end
      if (cnt !== exp_cnt) begin n_errors++; $display("FAIL all_cnt got %h exp %h", cnt, exp_cnt); end
      commit();
      lane_addr[i % 4] = 8'($urandom);
    end
  endtask

  task automatic test_pair();
    rst = 1'b1; req = 4'h0;
    observe(); commit();
    rst = 1'b0; req = 4'b0010; lane_addr[1] = 8'($urandom);
    observe(); commit();
    req = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      observe();
      n_checks += 5;
      if (gnt !== ((i % 2 == 0) ? 4'b1000 : 4'b0010)) begin n_errors++; $display("FAIL pair_gnt_order got %b step %0d", gnt, i); end
      if (rvalid !== exp_rvalid) begin n_errors++; $display("FAIL pair_rvalid got %b exp %b", rvalid, exp_rvalid); end
      if (rdata !== exp_rdata) begin n_errors++; $display("FAIL pair_rdata got %h exp %h", rdata, exp_rdata); end
      if (lut_addr !== exp_lut_addr) begin n_errors++; $display("FAIL pair_lut_addr got %h exp %h", lut_addr, exp_lut_addr); end
      if (cnt !== exp_cnt) begin n_errors++; $display("FAIL pair_cnt got %h exp %h", cnt, exp_cnt); end
      commit();
      lane_addr[m_gsel] = 8'($urandom);
    end
  endtask

  task automatic test_reset_mid();
    req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      observe(); commit();
      lane_addr[m_gsel] = 8'($urandom);
    end
    rst = 1'b1;
    observe();
    n_checks++;
    if (gnt !== 4'b0) begin n_errors++; $display("FAIL mid_rst_gnt got %b exp 0000", gnt); end
    commit();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      observe();
      n_checks += 3;
      if (i == 0 && (gnt !== 4'b0001 || rvalid !== 4'b0)) begin
        n_errors++; $display("FAIL mid_after_rst gnt %b rvalid %b exp 0001 0000", gnt, rvalid);
      end
      if (rvalid !== exp_rvalid) begin n_errors++; $display("FAIL mid_rvalid got %b exp %b", rvalid, exp_rvalid); end
      if (rdata !== exp_rdata) begin n_errors++; $display("FAIL mid_rdata got %h exp %h", rdata, exp_rdata); end
      commit();
      lane_addr[m_gsel] = 8'($urandom);
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1; req = 4'h0;
    observe(); commit();
    rst = 1'b0; req = 4'hF;
    for (int i = 0; i < 20; i++) begin
      observe(); commit();
    end
    req = 4'h0;
    observe();
    n_checks += 4;
    if (cnt4 !== exp_cnt4) begin n_errors++; $display("FAIL sat_cnt4_model got %h exp %h", cnt4, exp_cnt4); end
    if (cnt !== exp_cnt) begin n_errors++; $display("FAIL sat_cnt_model got %h exp %h", cnt, exp_cnt); end
`ifdef LUT_RD_STATS_EN
    if (cnt4 !== 4'hF) begin n_errors++; $display("FAIL sat_cnt4 got %h exp f", cnt4); end
    if (cnt !== 16'd20) begin n_errors++; $display("FAIL sat_cnt got %0d exp 20", cnt); end
`else
    if (cnt4 !== 4'h0) begin n_errors++; $display("FAIL sat_cnt4 got %h exp 0", cnt4); end
    if (cnt !== 16'h0) begin n_errors++; $display("FAIL sat_cnt got %h exp 0", cnt); end
`endif
    commit();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      observe();
      n_checks += 6;
      if (gnt !== exp_gnt) begin n_errors++; $display("FAIL rnd_gnt got %b exp %b", gnt, exp_gnt); end
      if (rvalid !== exp_rvalid) begin n_errors++; $display("FAIL rnd_rvalid got %b exp %b", rvalid, exp_rvalid); end
      if (rdata !== exp_rdata) begin n_errors++; $display("FAIL rnd_rdata got %h exp %h", rdata, exp_rdata); end
      if (lut_addr !== exp_lut_addr) begin n_errors++; $display("FAIL rnd_lut_addr got %h exp %h", lut_addr, exp_lut_addr); end
      if (cnt !== exp_cnt) begin n_errors++; $display("FAIL rnd_cnt got %h exp %h", cnt, exp_cnt); end
      if (cnt4 !== exp_cnt4) begin n_errors++; $display("FAIL rnd_cnt4 got %h exp %h", cnt4, exp_cnt4); end
      commit();
      // A lane keeps its request until granted, then may drop or re-request.
      for (int k = 0; k < 4; k++) begin
        if (!req[k] || k == m_gsel) begin
          req[k]       = 1'($urandom_range(0, 1));
          lane_addr[k] = 8'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'hF;
    for (int k = 0; k < 4; k++) lane_addr[k] = 8'($urandom);
    m_ptr = 0; m_cyc = 0; m_gsel = -1; m_cnt = 0; m_cnt4 = 0;
    m_rdata = '0; m_lut_addr = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_lane();
    test_all_lanes();
    test_pair();
    test_reset_mid();
    test_saturation();
    rst = 1'b0; req = 4'h0;
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
